// File: rtl/rv_p4_pkg.sv
// ============================================================================
// Module : rv_p4_pkg
// Brief  : Shared types and TUE CSR map for the table-update initiator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rv_p4_pkg;

    localparam int MAU_TCAM_KEY_W  = 512;
    localparam int TUE_INIT_NUM_WR = 40;

    localparam logic [11:0] TUE_REG_CMD       = 12'h000;
    localparam logic [11:0] TUE_REG_TABLE_ID  = 12'h004;
    localparam logic [11:0] TUE_REG_STAGE     = 12'h008;
    localparam logic [11:0] TUE_REG_KEY_0     = 12'h010;
    localparam logic [11:0] TUE_REG_MASK_0    = 12'h050;
    localparam logic [11:0] TUE_REG_ACTION_ID = 12'h090;
    localparam logic [11:0] TUE_REG_ACTION_P0 = 12'h094;
    localparam logic [11:0] TUE_REG_ACTION_P1 = 12'h098;
    localparam logic [11:0] TUE_REG_ACTION_P2 = 12'h09C;
    localparam logic [11:0] TUE_REG_COMMIT    = 12'h0A0;
    localparam logic [11:0] TUE_REG_STATUS    = 12'h0A4;

    typedef enum logic [1:0] {
        TI_OK      = 2'd0,
        TI_SLVERR  = 2'd1,
        TI_TIMEOUT = 2'd2
    } tue_init_rsp_t;

    typedef struct packed {
        logic [1:0]                cmd;
        logic [4:0]                stage;
        logic [15:0]               table_id;
        logic [MAU_TCAM_KEY_W-1:0] key;
        logic [MAU_TCAM_KEY_W-1:0] mask;
        logic [15:0]               action_id;
        logic [95:0]               params;
    } tue_entry_t;

endpackage

`default_nettype wire

// File: rtl/tue_cfg_wmux.sv
// ============================================================================
// Module : tue_cfg_wmux
// Brief  : Maps write-word index and latched entry to APB address/data.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tue_cfg_wmux
    import rv_p4_pkg::*;
(
    input  logic [5:0]  w_i,
    input  tue_entry_t  entry_i,
    output logic [11:0] paddr_o,
    output logic [31:0] pwdata_o
);

    logic [3:0] w_kidx;
    logic [1:0] w_pidx;

    always_comb begin
        w_kidx   = '0;
        w_pidx   = '0;
        paddr_o  = TUE_REG_COMMIT;
        pwdata_o = 32'h1;
        if (w_i == 6'd0) begin
            paddr_o  = TUE_REG_CMD;
            pwdata_o = {30'b0, entry_i.cmd};
        end else if (w_i == 6'd1) begin
            paddr_o  = TUE_REG_TABLE_ID;
            pwdata_o = {16'b0, entry_i.table_id};
        end else if (w_i == 6'd2) begin
            paddr_o  = TUE_REG_STAGE;
            pwdata_o = {27'b0, entry_i.stage};
        end else if (w_i <= 6'd18) begin
            w_kidx   = 4'(w_i - 6'd3);
            paddr_o  = TUE_REG_KEY_0 + {6'b0, w_kidx, 2'b00};
            pwdata_o = entry_i.key[{w_kidx, 5'b0} +: 32];
        end else if (w_i <= 6'd34) begin
            w_kidx   = 4'(w_i - 6'd19);
            paddr_o  = TUE_REG_MASK_0 + {6'b0, w_kidx, 2'b00};
            pwdata_o = entry_i.mask[{w_kidx, 5'b0} +: 32];
        end else if (w_i == 6'd35) begin
            paddr_o  = TUE_REG_ACTION_ID;
            pwdata_o = {16'b0, entry_i.action_id};
        end else if (w_i <= 6'd38) begin
            w_pidx   = 2'(w_i - 6'd36);
            paddr_o  = TUE_REG_ACTION_P0 + {8'b0, w_pidx, 2'b00};
            pwdata_o = entry_i.params[{w_pidx, 5'b0} +: 32];
        end
    end

endmodule

`default_nettype wire

// File: rtl/tue_cfg_initiator.sv
// ============================================================================
// Module : tue_cfg_initiator
// Brief  : APB master writing one table entry into the TUE, then polling STATUS.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tue_cfg_initiator
    import rv_p4_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int GRACE_POLLS    = 4
) (
    input  logic                      clk_ctrl,
    input  logic                      rst_ctrl_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_cmd,
    input  logic [4:0]                req_stage,
    input  logic [15:0]               req_table_id,
    input  logic [MAU_TCAM_KEY_W-1:0] req_key,
    input  logic [MAU_TCAM_KEY_W-1:0] req_mask,
    input  logic [15:0]               req_action_id,
    input  logic [95:0]               req_action_params,
    output logic                      rsp_valid,
    output logic [1:0]                rsp_status,
    output logic                      apb_psel,
    output logic                      apb_penable,
    output logic                      apb_pwrite,
    output logic [11:0]               apb_paddr,
    output logic [31:0]               apb_pwdata,
    input  logic [31:0]               apb_prdata,
    input  logic                      apb_pready,
    input  logic                      apb_pslverr
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GR_W  = $clog2(GRACE_POLLS + 1);
    localparam logic [5:0] LAST_W = 6'(TUE_INIT_NUM_WR - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WR_SETUP  = 3'd1;
    localparam logic [2:0] ST_WR_ACCESS = 3'd2;
    localparam logic [2:0] ST_WR_GAP    = 3'd3;
    localparam logic [2:0] ST_RD_SETUP  = 3'd4;
    localparam logic [2:0] ST_RD_ACCESS = 3'd5;
    localparam logic [2:0] ST_RD_GAP    = 3'd6;
    localparam logic [2:0] ST_RESP      = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [5:0]       w_q, w_d;
    tue_entry_t       entry_q, entry_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [GR_W-1:0]  grace_q, grace_d;
    logic             seen_busy_q, seen_busy_d;
    tue_init_rsp_t    status_q, status_d;

    logic [11:0] w_mux_addr;
    logic [31:0] w_mux_data;
    logic        w_wr_act;
    logic        w_rd_act;
    logic        w_poll;
    logic        w_expired;
    logic        w_unused_prdata;

    tue_cfg_wmux u_wmux (
        .w_i      (w_q),
        .entry_i  (entry_q),
        .paddr_o  (w_mux_addr),
        .pwdata_o (w_mux_data)
    );

    assign w_wr_act  = (state_q == ST_WR_SETUP) || (state_q == ST_WR_ACCESS);
    assign w_rd_act  = (state_q == ST_RD_SETUP) || (state_q == ST_RD_ACCESS);
    assign w_poll    = w_rd_act || (state_q == ST_RD_GAP);
    assign w_expired = (tmo_q == '0);
    assign w_unused_prdata = ^apb_prdata[31:2];

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        entry_d     = entry_q;
        tmo_d       = tmo_q;
        grace_d     = grace_q;
        seen_busy_d = seen_busy_q;
        status_d    = status_q;

        if (w_poll && !w_expired) begin
            tmo_d = tmo_q - TMO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    entry_d = '{cmd: req_cmd, stage: req_stage, table_id: req_table_id,
                                key: req_key, mask: req_mask, action_id: req_action_id,
                                params: req_action_params};
                    w_d     = '0;
                    state_d = ST_WR_SETUP;
                end
            end
            ST_WR_SETUP: state_d = ST_WR_ACCESS;
            ST_WR_ACCESS: begin
                if (apb_pready) begin
                    if (apb_pslverr) begin
                        status_d = TI_SLVERR;
                        state_d  = ST_RESP;
                    end else if (w_q == LAST_W) begin
                        tmo_d       = TMO_W'(TIMEOUT_CYCLES);
                        grace_d     = '0;
                        seen_busy_d = 1'b0;
                        state_d     = ST_RD_GAP;
                    end else begin
                        state_d = ST_WR_GAP;
                    end
                end
            end
            ST_WR_GAP: begin
                w_d     = w_q + 6'd1;
                state_d = ST_WR_SETUP;
            end
            ST_RD_GAP: begin
                if (w_expired) begin
                    status_d = TI_TIMEOUT;
                    state_d  = ST_RESP;
                end else begin
                    state_d = ST_RD_SETUP;
                end
            end
            // An expired timer still lets the in-flight read finish.
            ST_RD_SETUP: state_d = ST_RD_ACCESS;
            ST_RD_ACCESS: begin
                if (apb_pready) begin
                    state_d = ST_RD_GAP;
                    if (w_expired) begin
                        status_d = TI_TIMEOUT;
                        state_d  = ST_RESP;
                    end else if (apb_pslverr) begin
                        status_d = TI_SLVERR;
                        state_d  = ST_RESP;
                    end else begin
                        case (apb_prdata[1:0])
                            2'd2: begin
                                status_d = TI_OK;
                                state_d  = ST_RESP;
                            end
                            2'd1: seen_busy_d = 1'b1;
                            2'd3: begin
                                status_d = TI_SLVERR;
                                state_d  = ST_RESP;
                            end
                            default: begin
                                // Idle after busy means the one-cycle done was missed.
                                if (seen_busy_q || (grace_q + GR_W'(1) == GR_W'(GRACE_POLLS))) begin
                                    status_d = TI_OK;
                                    state_d  = ST_RESP;
                                end else begin
                                    grace_d = grace_q + GR_W'(1);
                                end
                            end
                        endcase
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_ctrl) begin
        if (!rst_ctrl_n) begin
            state_q     <= ST_IDLE;
            w_q         <= '0;
            entry_q     <= '0;
            tmo_q       <= '0;
            grace_q     <= '0;
            seen_busy_q <= 1'b0;
            status_q    <= TI_OK;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            entry_q     <= entry_d;
            tmo_q       <= tmo_d;
            grace_q     <= grace_d;
            seen_busy_q <= seen_busy_d;
            status_q    <= status_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_status  = status_q;
    assign apb_psel    = w_wr_act || w_rd_act;
    assign apb_penable = (state_q == ST_WR_ACCESS) || (state_q == ST_RD_ACCESS);
    assign apb_pwrite  = w_wr_act;
    assign apb_paddr   = w_wr_act ? w_mux_addr : (w_rd_act ? TUE_REG_STATUS : 12'h000);
    assign apb_pwdata  = w_wr_act ? w_mux_data : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_tue_cfg_initiator.sv
// ============================================================================
// Module : tb_tue_cfg_initiator
// Brief  : Self-checking bench with APB slave model and write/rsp scoreboards.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tue_cfg_initiator;

    localparam int TMO   = 256;
    localparam int GRACE = 4;

    logic         clk_ctrl = 1'b0;
    logic         rst_ctrl_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_cmd = '0;
    logic [4:0]   req_stage = '0;
    logic [15:0]  req_table_id = '0;
    logic [511:0] req_key = '0;
    logic [511:0] req_mask = '0;
    logic [15:0]  req_action_id = '0;
    logic [95:0]  req_action_params = '0;
    logic         rsp_valid;
    logic [1:0]   rsp_status;
    logic         apb_psel, apb_penable, apb_pwrite;
    logic [11:0]  apb_paddr;
    logic [31:0]  apb_pwdata;
    logic [31:0]  apb_prdata = '0;
    logic         apb_pready = 1'b0;
    logic         apb_pslverr = 1'b0;

    tue_cfg_initiator #(.TIMEOUT_CYCLES(TMO), .GRACE_POLLS(GRACE)) dut (
        .clk_ctrl(clk_ctrl), .rst_ctrl_n(rst_ctrl_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_stage(req_stage), .req_table_id(req_table_id),
        .req_key(req_key), .req_mask(req_mask), .req_action_id(req_action_id),
        .req_action_params(req_action_params),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
        .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
        .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
    );

    always #5 clk_ctrl = ~clk_ctrl;

    typedef struct {
        logic [1:0]  cmd;
        logic [4:0]  stage;
        logic [15:0] tid;
        logic [15:0] aid;
        int waits, err_w, n_busy, tail, exp_rsp, exp_reads, pat, chk_tmo;
    } vec_t;

    typedef struct { logic [11:0] a; logic [31:0] d; } wr_t;

    wr_t        wq[$];
    logic [1:0] rq[$];
    vec_t       vecs[10];

    int n_chk = 0, n_pass = 0;
    int cyc = 0, rsp_cnt = 0, rsp_cyc = 0, commit_cyc = 0;
    int cur_waits = 0, cur_err = -1, cur_busy = 0, cur_tail = 2;
    int rd_cnt = 0, wr_done = 0, bb_bad = 0;

    always @(posedge clk_ctrl) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic fail(input string nm);
        n_chk++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic vec_t mk(input int cmd, input int stage, input int tid, input int aid,
                                input int waits, input int err_w, input int n_busy,
                                input int tail, input int exp_rsp, input int exp_reads,
                                input int pat, input int chk_tmo);
        vec_t v;
        v.cmd = 2'(cmd); v.stage = 5'(stage); v.tid = 16'(tid); v.aid = 16'(aid);
        v.waits = waits; v.err_w = err_w; v.n_busy = n_busy; v.tail = tail;
        v.exp_rsp = exp_rsp; v.exp_reads = exp_reads; v.pat = pat; v.chk_tmo = chk_tmo;
        return v;
    endfunction

    // APB slave: wait states, write/read scoreboard, STATUS script
    initial begin : slave
        logic [11:0] cap_a;
        logic [31:0] cap_d;
        logic        cap_w, unstable, prev_psel;
        int          wcnt;
        wr_t         e;
        cap_a = '0; cap_d = '0; cap_w = 1'b0; unstable = 1'b0; prev_psel = 1'b0; wcnt = 0;
        forever begin
            @(negedge clk_ctrl);
            if (!rst_ctrl_n || !apb_psel) begin
                apb_pready = 1'b0; apb_pslverr = 1'b0; apb_prdata = '0; wcnt = 0;
            end else if (!apb_penable) begin
                if (prev_psel) bb_bad++;
                cap_a = apb_paddr; cap_d = apb_pwdata; cap_w = apb_pwrite; unstable = 1'b0;
                apb_pready = 1'b0;
            end else begin
                if (apb_paddr !== cap_a || apb_pwdata !== cap_d || apb_pwrite !== cap_w)
                    unstable = 1'b1;
                if (wcnt < cur_waits) begin
                    wcnt++;
                    apb_pready = 1'b0;
                end else begin
                    apb_pready = 1'b1; apb_pslverr = 1'b0; apb_prdata = '0;
                    check("stable_phase", 64'(unstable), 64'd0);
                    if (apb_pwrite) begin
                        if (apb_paddr == 12'h0A0) commit_cyc = cyc;
                        if (wq.size() == 0) begin
                            $display("FAIL extra_write: addr %0h data %0h", apb_paddr, apb_pwdata);
                            n_chk++;
                        end else begin
                            e = wq.pop_front();
                            check("wr_addr", 64'(apb_paddr), 64'(e.a));
                            check("wr_data", 64'(apb_pwdata), 64'(e.d));
                        end
                        if (wr_done == cur_err) apb_pslverr = 1'b1;
                        wr_done++;
                    end else begin
                        rd_cnt++;
                        check("rd_addr", 64'(apb_paddr), 64'h0A4);
                        if (rd_cnt <= cur_busy) apb_prdata = {30'h2AAA_AAAA, 2'b01};
                        else if (cur_tail == 4) apb_pslverr = 1'b1;
                        else apb_prdata = {30'h2AAA_AAAA, 2'(cur_tail)};
                    end
                end
            end
            prev_psel = apb_psel;
        end
    end

    always @(negedge clk_ctrl) begin
        if (rst_ctrl_n && rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            if (rq.size() == 0) begin
                $display("FAIL unexpected_rsp: status %0d", rsp_status);
                n_chk++;
            end else begin
                check("rsp_status", 64'(rsp_status), 64'(rq.pop_front()));
            end
        end
    end

    task automatic push_wr(input int idx, input int last, input logic [11:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a; e.d = d;
        if (idx <= last) wq.push_back(e);
    endtask

    task automatic prep_and_send(input vec_t v);
        logic [511:0] key, mask;
        logic [95:0]  prm;
        int last;
        for (int k = 0; k < 16; k++) begin
            key[32*k +: 32]  = (v.pat == 0) ? 32'hA000_0000 + 32'(k) : $urandom;
            mask[32*k +: 32] = (v.pat == 0) ? 32'hFFFF_FFFF : $urandom;
        end
        for (int j = 0; j < 3; j++) prm[32*j +: 32] = $urandom;
        cur_waits = v.waits; cur_err = v.err_w; cur_busy = v.n_busy; cur_tail = v.tail;
        rd_cnt = 0; wr_done = 0; bb_bad = 0;
        last = (v.err_w >= 0) ? v.err_w : 39;
        push_wr(0, last, 12'h000, {30'b0, v.cmd});
        push_wr(1, last, 12'h004, {16'b0, v.tid});
        push_wr(2, last, 12'h008, {27'b0, v.stage});
        for (int k = 0; k < 16; k++) push_wr(3 + k, last, 12'h010 + 12'(4*k), key[32*k +: 32]);
        for (int k = 0; k < 16; k++) push_wr(19 + k, last, 12'h050 + 12'(4*k), mask[32*k +: 32]);
        push_wr(35, last, 12'h090, {16'b0, v.aid});
        for (int j = 0; j < 3; j++) push_wr(36 + j, last, 12'h094 + 12'(4*j), prm[32*j +: 32]);
        push_wr(39, last, 12'h0A0, 32'h1);
        rq.push_back(2'(v.exp_rsp));

        for (int i = 0; i < 50 && !req_ready; i++) begin @(negedge clk_ctrl); #1; end
        if (!req_ready) fail("req_ready_wait");
        req_valid = 1'b1; req_cmd = v.cmd; req_stage = v.stage; req_table_id = v.tid;
        req_key = key; req_mask = mask; req_action_id = v.aid; req_action_params = prm;
        @(negedge clk_ctrl); #1;
        req_valid = 1'b0;
        check("ready_drop", 64'(req_ready), 64'd0);
    endtask

    task automatic run_case(input vec_t v);
        int start, got, delay;
        start = rsp_cnt; got = 0;
        prep_and_send(v);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_ctrl); #1;
            if (rsp_cnt != start) begin got = 1; break; end
        end
        if (got == 0) begin
            fail("rsp_wait");
        end else begin
            delay = rsp_cyc - commit_cyc;
            check("ready_in_resp", 64'(req_ready), 64'd0);
            @(negedge clk_ctrl); #1;
            check("ready_after", 64'(req_ready), 64'd1);
            check("rsp_one_cycle", 64'(rsp_valid), 64'd0);
            check("writes_left", 64'(wq.size()), 64'd0);
            check("back_to_back", 64'(bb_bad), 64'd0);
            if (v.exp_reads >= 0) check("read_count", 64'(rd_cnt), 64'(v.exp_reads));
            if (v.chk_tmo != 0)
                check("tmo_window", 64'((delay >= TMO) && (delay <= TMO + 3)), 64'd1);
        end
        rq.delete();
        wq.delete();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int saved, hit;
        //            cmd stg   tid     aid   wt err busy tail rsp reads pat tmo
        vecs[0] = mk(0, 3,    16'h0012, 7,      0, -1, 5, 2, 0, 6,  0, 0);
        vecs[1] = mk(0, 3,    16'h0012, 7,      0, 17, 5, 2, 1, 0,  0, 0);
        vecs[2] = mk(0, 3,    16'h0012, 7,      0, -1, 0, 1, 2, -1, 0, 1);
        vecs[3] = mk(0, 3,    16'h0012, 7,      4, -1, 5, 2, 0, 6,  0, 0);
        vecs[4] = mk(0, 3,    16'h0012, 7,      0, -1, 3, 0, 0, 4,  0, 0);
        vecs[5] = mk(0, 3,    16'h0012, 7,      0, -1, 0, 0, 0, GRACE, 0, 0);
        vecs[6] = mk(3, 5'h1F, 16'hBEEF, 16'h1234, 0, -1, 1, 3, 1, 2, 1, 0);
        vecs[7] = mk(2, 5'h1F, 16'hFFFF, 16'hFFFF, 0, 39, 0, 2, 1, 0, 1, 0);
        vecs[8] = mk(1, 0,    16'h0001, 16'h8000, 1, -1, 0, 2, 0, 1, 1, 0);
        vecs[9] = mk(0, 17,   16'h00A5, 3,      2, -1, 2, 4, 1, 3,  1, 0);

        repeat (3) @(negedge clk_ctrl);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_status", 64'(rsp_status), 64'd0);
        check("rst_psel", 64'(apb_psel), 64'd0);
        check("rst_penable", 64'(apb_penable), 64'd0);
        check("rst_pwrite", 64'(apb_pwrite), 64'd0);
        check("rst_paddr", 64'(apb_paddr), 64'd0);
        check("rst_pwdata", 64'(apb_pwdata), 64'd0);
        rst_ctrl_n = 1'b1;
        @(negedge clk_ctrl); #1;

        for (int i = 0; i < 10; i++) run_case(vecs[i]);

        // reset in the SETUP phase of word 20
        prep_and_send(vecs[0]);
        hit = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_ctrl); #1;
            if (wr_done == 20 && apb_psel && !apb_penable) begin hit = 1; break; end
        end
        if (hit == 0) fail("reach_w20");
        check("w20_addr", 64'(apb_paddr), 64'h054);
        saved = rsp_cnt;
        rst_ctrl_n = 1'b0;
        @(negedge clk_ctrl); #1;
        check("mid_rst_psel", 64'(apb_psel), 64'd0);
        check("mid_rst_penable", 64'(apb_penable), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd1);
        rst_ctrl_n = 1'b1;
        wq.delete();
        rq.delete();
        repeat (10) @(negedge clk_ctrl);
        #1;
        check("mid_rst_no_rsp", 64'(rsp_cnt), 64'(saved));
        check("mid_rst_idle_psel", 64'(apb_psel), 64'd0);
        run_case(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tue_cfg_initiator.md
Name: tue_cfg_initiator

Overview:
- APB master that drives a table-update transaction into the Table Update Engine's APB slave register file.
- It accepts one complete table entry per valid/ready handshake: cmd, stage, table_id, key, mask, action_id and params.
- It serialises the entry into the TUE register write sequence, writes COMMIT, then polls STATUS until the update completes or times out.
- It sits in the clk_ctrl domain between the control-plane command source and the TUE CSR port.

Parameters:
- TIMEOUT_CYCLES, 256: clk_ctrl cycles allowed from COMMIT write completion to detected completion.
- GRACE_POLLS, 4: number of STATUS reads returning idle, before any busy has been seen, that are tolerated as "not yet started".

Ports:
- clk_ctrl  input  1  control clock
- rst_ctrl_n  input  1  synchronous active-low reset
- req_valid  input  1  entry valid
- req_ready  output  1  initiator idle, can accept an entry
- req_cmd  input  2  TUE_INSERT/DELETE/MODIFY/FLUSH
- req_stage  input  5  MAU stage; 5'h1F selects the parser
- req_table_id  input  16  table/entry index
- req_key  input  MAU_TCAM_KEY_W  key (512)
- req_mask  input  MAU_TCAM_KEY_W  mask (512)
- req_action_id  input  16  action id
- req_action_params  input  96  action params
- rsp_valid  output  1  one-cycle completion pulse
- rsp_status  output  2  0=OK, 1=SLVERR, 2=TIMEOUT
- apb_psel  output  1  APB select
- apb_penable  output  1  APB enable
- apb_pwrite  output  1  APB write
- apb_paddr  output  12  APB address
- apb_pwdata  output  32  APB write data
- apb_prdata  input  32  APB read data
- apb_pready  input  1  APB ready
- apb_pslverr  input  1  APB slave error

Behaviour:
- Reset (sync, active-low): state IDLE; req_ready=1; rsp_valid=0; rsp_status=0; apb_psel/penable/pwrite=0; paddr/pwdata=0; all counters 0. A reset asserted mid-transaction drops psel/penable at the next edge and emits no rsp.
- Accept: req_valid && req_ready latches all req_* into internal registers. req_ready=0 from the next cycle until the cycle after rsp_valid.
- Write sequence: word index w=0..39, in this fixed order:
  - w=0: CMD, data {30'b0,cmd}
  - w=1: TABLE_ID, data {16'b0,table_id}
  - w=2: STAGE, data {27'b0,stage}
  - w=3..18: KEY_0+4k, data key[32k+:32]
  - w=19..34: MASK_0+4k, data mask[32k+:32]
  - w=35: ACTION_ID, data {16'b0,action_id}
  - w=36..38: ACTION_P0..P2, data params[32j+:32]
  - w=39: COMMIT, data 32'h1
- FLUSH issues the full sequence unchanged.
- APB transfer:
  - SETUP: psel=1, penable=0, for one cycle.
  - ACCESS: psel=1, penable=1, held until pready.
  - paddr, pwrite and pwdata stay stable across both phases.
  - On a pready cycle, psel/penable drop for at least one cycle; there are no back-to-back transfers.
  - Minimum 3 cycles per word.
- Error during writes: pready && pslverr aborts. No further writes are issued, COMMIT included. The block emits rsp SLVERR and returns to IDLE.
- Poll phase (entered after COMMIT completes):
  - The timeout counter is loaded with TIMEOUT_CYCLES.
  - The block repeatedly reads STATUS, pwrite=0, using the same SETUP/ACCESS/idle rhythm.
  - On each completed read, s=prdata[1:0]:
    - s==2 (done): OK.
    - s==1: set seen_busy.
    - s==0 and seen_busy: OK, because the one-cycle done was missed.
    - s==0 and !seen_busy: increment grace; when grace reaches GRACE_POLLS, OK.
    - s==3: SLVERR.
    - pslverr on a read: SLVERR.
- Timeout: the counter decrements every cycle in poll. When it hits 0 with no result, the block finishes the in-flight read, ignores its data, and emits TIMEOUT.
- Response: rsp_valid high for exactly one cycle with rsp_status; next cycle the state is IDLE and req_ready=1.
- States: IDLE, WR_SETUP, WR_ACCESS, WR_GAP, RD_SETUP, RD_ACCESS, RD_GAP, RESP.
- Nominal latency with zero-wait pready: 40×3 write cycles, then polls, then 1 cycle RESP.

Decomposition:
- rv_p4_pkg:
  - tue_init_rsp_t enum {TI_OK, TI_SLVERR, TI_TIMEOUT}
  - TUE_INIT_NUM_WR=40
  - reuse existing TUE_REG_* address constants
- Sub-module tue_cfg_wmux: combinational map of (w, latched entry) to (paddr, pwdata).

Test Plan:
1. Insert, stage 3, table_id 0x0012, key word k=32'hA000_0000+k, mask all-ones, action_id 0x0007, zero-wait slave, STATUS busy ×5 then done -> 40 writes in listed order with exact addr/data, COMMIT data 1, rsp OK once, req_ready back to 1.
2. Slave asserts pslverr on w=17 (KEY_14) -> no writes for w≥18, no COMMIT, rsp SLVERR.
3. STATUS stuck at 1 -> rsp TIMEOUT within TIMEOUT_CYCLES+3 cycles of COMMIT completion.
4. pready low for 4 cycles on every access -> paddr/pwdata stable while waiting, sequence identical to test 1.
5. STATUS returns busy ×3 then idle (done missed) -> OK; STATUS idle from the first poll -> OK after exactly GRACE_POLLS reads.
6. rst_ctrl_n low at w=20 for 1 cycle -> psel=0 on the next cycle, no rsp, req_ready=1; a subsequent request restarts at w=0.
